// File: rtl/toggle_event_decoder.sv
// Receive-side decoder for a toggle-encoded event line: synchronizes the wire,
// turns each level change into one event and buffers events behind valid/ready.
//
// state | meaning
// ARM   | after reset: let the synchronizer settle, prev_q tracks sync_q, no events
// RUN   | normal operation: each sync_q level change is one event
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             clr_ovf,
    output logic             evt_valid,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic [15:0]      evt_count
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 1) + 1;
    // ARM spans one edge more than the chain depth, so a level already present
    // at reset release has reached prev_q before edges are qualified.
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    typedef enum logic {
        ARM = 1'b0,
        RUN = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic                   prev_q;
    logic [ARM_W-1:0]       arm_cnt;
    logic                   edge_det;
    logic                   evt_edge;
    logic                   accept;

    assign sync_q    = sync_ff[SYNC_STAGES-1];
    assign edge_det  = sync_q ^ prev_q;
    assign evt_edge  = edge_det && (state == RUN);
    assign evt_valid = (pending != '0);
    assign accept    = evt_valid && evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], tog_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARM;
            arm_cnt   <= '0;
            prev_q    <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
            evt_count <= '0;
        end else begin
            prev_q <= sync_q;

            case (state)
                ARM: begin
                    if (arm_cnt == ARM_DONE) begin
                        state <= RUN;
                    end else begin
                        arm_cnt <= arm_cnt + ARM_W'(1);
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= ARM;
                end
            endcase

            // A simultaneous arrival and consume cancel out, even when full.
            if (evt_edge && !accept) begin
                if (pending != PEND_MAX) begin
                    pending <= pending + CNT_W'(1);
                end
            end else if (accept && !evt_edge) begin
                pending <= pending - CNT_W'(1);
            end

            if (evt_edge && !accept && (pending == PEND_MAX)) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end

            if (evt_edge) begin
                evt_count <= evt_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench: default-size decoder (a) and a CNT_W=2 decoder (b) for saturation cases.
module tb_toggle_event_decoder;

    logic clk;
    logic rst_n;

    logic       tog_a, rdy_a, clr_a;
    logic       valid_a, ovf_a;
    logic [3:0] pend_a;
    logic [15:0] cnt_a;

    logic       tog_b, rdy_b, clr_b;
    logic       valid_b, ovf_b;
    logic [1:0] pend_b;
    logic [15:0] cnt_b;

    int tests_run;
    int tests_failed;
    int nvalid;

    toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .tog_in(tog_a), .evt_ready(rdy_a), .clr_ovf(clr_a),
        .evt_valid(valid_a), .pending(pend_a), .overflow(ovf_a), .evt_count(cnt_a)
    );

    toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .tog_in(tog_b), .evt_ready(rdy_b), .clr_ovf(clr_b),
        .evt_valid(valid_b), .pending(pend_b), .overflow(ovf_b), .evt_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        tog_a = 1'b0; rdy_a = 1'b0; clr_a = 1'b0;
        tog_b = 1'b1; rdy_b = 1'b0; clr_b = 1'b0;

        // 1: static high tog_in across reset release gives no event
        #1;
        check("rst_pend_b", {30'd0, pend_b}, 32'd0);
        check("rst_valid_b", {31'd0, valid_b}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("arm_quiet_b", {valid_b, ovf_b, pend_b, cnt_b}, 32'd0);
        end
        check("arm_quiet_a", {valid_a, ovf_a, pend_a, cnt_a}, 32'd0);

        // 2: one toggle, three-edge latency, then one consume
        tog_a = 1'b1;
        tick(); tick();
        check("lat_e2_valid", {31'd0, valid_a}, 32'd0);
        tick();
        check("lat_e3_valid", {31'd0, valid_a}, 32'd1);
        check("lat_e3_pend", {28'd0, pend_a}, 32'd1);
        check("lat_e3_cnt", {16'd0, cnt_a}, 32'd1);
        rdy_a = 1'b1;
        tick();
        rdy_a = 1'b0;
        check("consume_pend", {28'd0, pend_a}, 32'd0);
        check("consume_valid", {31'd0, valid_a}, 32'd0);

        // 3: four buffered events drained one per cycle
        for (int i = 0; i < 4; i++) begin
            tog_a = ~tog_a;
            repeat (4) tick();
        end
        check("burst_pend", {28'd0, pend_a}, 32'd4);
        check("burst_cnt", {16'd0, cnt_a}, 32'd5);
        rdy_a = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid_a) nvalid++;
            tick();
        end
        check("drain_cycles", nvalid, 32'd4);
        check("drain_pend", {28'd0, pend_a}, 32'd0);
        tick();
        check("no_underflow", {28'd0, pend_a}, 32'd0);
        rdy_a = 1'b0;

        // 4: saturation at 3 with CNT_W=2, then clear overflow
        for (int i = 0; i < 5; i++) begin
            tog_b = ~tog_b;
            repeat (4) tick();
        end
        check("sat_pend", {30'd0, pend_b}, 32'd3);
        check("sat_ovf", {31'd0, ovf_b}, 32'd1);
        check("sat_cnt", {16'd0, cnt_b}, 32'd5);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        check("clr_ovf", {31'd0, ovf_b}, 32'd0);
        check("clr_pend", {30'd0, pend_b}, 32'd3);

        // 5: arrival coincides with consume while full
        tog_b = ~tog_b;
        tick(); tick();
        rdy_b = 1'b1;
        tick();
        rdy_b = 1'b0;
        check("coin_pend", {30'd0, pend_b}, 32'd3);
        check("coin_ovf", {31'd0, ovf_b}, 32'd0);
        check("coin_cnt", {16'd0, cnt_b}, 32'd6);

        // 6: async reset mid-cycle with two pending, then rearm
        for (int i = 0; i < 2; i++) begin
            tog_a = ~tog_a;
            repeat (4) tick();
        end
        check("pre_rst_pend", {28'd0, pend_a}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pend", {28'd0, pend_a}, 32'd0);
        check("async_valid", {31'd0, valid_a}, 32'd0);
        check("async_cnt", {16'd0, cnt_a}, 32'd0);
        check("async_ovf_b", {31'd0, ovf_b}, 32'd0);
        tick();
        #3;
        rst_n = 1'b1;
        repeat (6) tick();
        check("rearm_quiet", {valid_a, pend_a, cnt_a}, 32'd0);
        tog_a = ~tog_a;
        tick(); tick();
        check("rearm_e2", {31'd0, valid_a}, 32'd0);
        tick();
        check("rearm_pend", {28'd0, pend_a}, 32'd1);
        check("rearm_cnt", {16'd0, cnt_a}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
